// File: rtl/mm_console_master_rsp_timing_adt_if.sv
// Interface for the console-master return-path timing adapter.
// Upstream side uses ready latency 0. A beat moves on a cycle where in_valid && in_ready,
// in_valid/in_data hold until accepted, and in_ready never waits on in_valid. The sink side
// has no second handshake: out_valid is only raised in grant slots, and the sink must take it.
interface mm_console_master_rsp_timing_adt_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_W     = 2
);
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_ready;
    logic [ADDR_W:0]       fill_level;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, fill_level
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, fill_level
    );
endinterface

// File: rtl/mm_console_master_rsp_timing_adt.sv
// Return-path timing adapter: ready-latency-0 upstream into a small FIFO, drained only in
// grant slots derived from the sink's out_ready delayed by OUT_READY_LATENCY cycles.
module mm_console_master_rsp_timing_adt #(
    parameter int DATA_WIDTH        = 8,
    parameter int OUT_READY_LATENCY = 1,
    parameter int FIFO_DEPTH        = 4,
    parameter int ADDR_W            = 2
) (
    input  logic clk,
    input  logic reset_n,
    mm_console_master_rsp_timing_adt_if.slave bus
);
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [ADDR_W-1:0]     wr_ptr;
    logic [ADDR_W-1:0]     rd_ptr;
    logic [ADDR_W:0]       count;
    logic                  run_q;
    logic                  grant;
    logic                  in_ready_c;
    logic                  out_valid_c;
    logic                  push;
    logic                  pop;

    // Ready delay line: the grant for this cycle is the sink's out_ready from L cycles ago.
    generate
        if (OUT_READY_LATENCY == 0) begin : g_no_dly
            assign grant = bus.out_ready;
        end else begin : g_dly
            logic [OUT_READY_LATENCY-1:0] dly_q;
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    dly_q <= '0;
                end else begin
                    dly_q[0] <= bus.out_ready;
                    for (int i = 1; i < OUT_READY_LATENCY; i++) begin
                        dly_q[i] <= dly_q[i-1];
                    end
                end
            end
            assign grant = dly_q[OUT_READY_LATENCY-1];
        end
    endgenerate

    // run_q holds in_ready low during reset and rises on the first edge after release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    assign in_ready_c  = run_q && (count < DEPTH_C);
    assign out_valid_c = grant && (count != '0);
    assign push        = bus.in_valid && in_ready_c;
    assign pop         = out_valid_c;

    assign bus.in_ready   = in_ready_c;
    assign bus.out_valid  = out_valid_c;
    assign bus.out_data   = (count != '0) ? mem[rd_ptr] : '0;
    assign bus.fill_level = count;

    // Storage has no reset; count gates every read so stale entries are never visible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.in_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_mm_console_master_rsp_timing_adt.sv
// Randomized scoreboard bench for the console-master return-path timing adapter.
module tb_mm_console_master_rsp_timing_adt;
  localparam int DW    = 8;
  localparam int L     = 2;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  mm_console_master_rsp_timing_adt_if #(.DATA_WIDTH(DW), .ADDR_W(AW)) bus ();

  mm_console_master_rsp_timing_adt #(
    .DATA_WIDTH(DW), .OUT_READY_LATENCY(L), .FIFO_DEPTH(DEPTH), .ADDR_W(AW)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  // ---------------- reference model / scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  bit            rlog[$];   // out_ready history, newest first
  int            m_cnt = 0;
  bit            m_run = 0;
  bit            last_push = 0;
  int            beats_seen = 0;
  int            checks = 0;
  int            errors = 0;

  function automatic bit model_grant();
    if (L == 0) return bus.out_ready;
    if (rlog.size() >= L) return rlog[L-1];
    return 1'b0;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Model state advance on each edge; async reset discards everything.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_cnt = 0;
      m_run = 0;
      last_push = 0;
      rlog.delete();
      exp_q.delete();
    end else begin
      bit g, push, pop;
      g    = model_grant();
      push = bus.in_valid && m_run && (m_cnt < DEPTH);
      pop  = g && (m_cnt > 0);
      if (push) exp_q.push_back(bus.in_data);
      last_push = push;
      m_cnt = m_cnt + int'(push) - int'(pop);
      rlog.push_front(bus.out_ready);
      if (rlog.size() > L) void'(rlog.pop_back());
      m_run = 1;
    end
  end

  // Status checks and data monitor, sampled mid-cycle.
  always @(negedge clk) begin
    bit exp_ir, exp_ov;
    exp_ir = reset_n && m_run && (m_cnt < DEPTH);
    exp_ov = reset_n && model_grant() && (m_cnt > 0);
    check("in_ready", int'(bus.in_ready), int'(exp_ir));
    check("out_valid", int'(bus.out_valid), int'(exp_ov));
    check("fill_level", int'(bus.fill_level), m_cnt);
    if (m_cnt == 0) check("out_data_empty", int'(bus.out_data), 0);
    if (bus.out_valid) begin
      beats_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL out_data_unexpected: got 0x%0h expected no beat at %0t", bus.out_data, $time);
      end else begin
        check("out_data", int'(bus.out_data), int'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  bit      use_seq = 0;
  logic [DW-1:0] seq_byte = '0;

  task automatic drive(input int n, input int vpct, input int rpct);
    for (int i = 0; i < n; i++) begin
      if (!bus.in_valid || last_push) begin
        bus.in_valid = ($urandom_range(1, 100) <= vpct);
        if (bus.in_valid) begin
          bus.in_data = use_seq ? seq_byte : DW'($urandom);
          if (use_seq) seq_byte++;
        end
      end
      bus.out_ready = ($urandom_range(1, 100) <= rpct);
      @(posedge clk); #1;
    end
  endtask

  task automatic idle(input int n, input bit r);
    bus.in_valid  = 1'b0;
    bus.out_ready = r;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;

    // In-order continuous stream with the sink always ready.
    use_seq = 1; seq_byte = 8'h01;
    drive(20, 100, 100);

    // Sink drops ready mid-stream: exactly L beats escape, then the FIFO fills.
    seq_byte = 8'h20;
    drive(4, 100, 100);
    b0 = beats_seen;
    drive(6, 100, 0);
    check("beats_after_drop", beats_seen - b0, L);
    check("fill_after_drop", int'(bus.fill_level), DEPTH);
    check("in_ready_full", int'(bus.in_ready), 0);
    drive(12, 100, 100);

    // Steady push/pop at level 2 wrapping the pointers.
    idle(10, 1'b1);
    idle(4, 1'b0);
    seq_byte = 8'hA0;
    drive(7, 100, 100);
    check("fill_steady_two", int'(bus.fill_level), 2);

    // Random traffic.
    use_seq = 0;
    drive(300, 70, 60);
    drive(150, 95, 30);
    drive(150, 30, 90);

    // Reset with three bytes stored: contents must be dropped immediately.
    idle(10, 1'b1);
    idle(4, 1'b0);
    drive(3, 100, 0);
    check("fill_before_reset", int'(bus.fill_level), 3);
    bus.in_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_fill_level", int'(bus.fill_level), 0);
    check("rst_in_ready", int'(bus.in_ready), 0);
    bus.out_ready = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    use_seq = 1; seq_byte = 8'h55;
    drive(40, 80, 70);
    use_seq = 0;
    drive(200, 60, 60);

    // Drain with a bounded wait.
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 50 && (exp_q.size() != 0 || m_cnt != 0); i++) begin
      @(posedge clk); #1;
    end
    check("drain_exp_q_empty", exp_q.size(), 0);
    check("drain_fill_level", int'(bus.fill_level), 0);
    idle(3, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/mm_console_master_rsp_timing_adt.md
Name: mm_console_master_rsp_timing_adt

Overview:
Return-path timing adapter for the console master. It accepts response bytes from the upstream packet/byte stage on a ready/valid interface with ready latency 0. It delivers them to the console byte sink, whose out_ready has a ready latency of OUT_READY_LATENCY cycles. A small FIFO absorbs bytes that are in flight when the sink deasserts ready, so data is never dropped and the sink never sees a beat it did not grant.

Parameters:
DATA_WIDTH, 8, payload width in bits
OUT_READY_LATENCY, 1, downstream ready latency in cycles (legal 0..3)
FIFO_DEPTH, 4, entries; power of two, must be >= OUT_READY_LATENCY+1
ADDR_W, 2, log2(FIFO_DEPTH); pointer width

Ports:
clk  input  1  sole clock, all state on rising edge
reset_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream beat valid
in_data  input  DATA_WIDTH  upstream payload
in_ready  output  1  upstream may transfer this cycle (ready latency 0)
out_valid  output  1  beat presented to sink; sink must accept it
out_data  output  DATA_WIDTH  payload to sink
out_ready  input  1  sink grant; takes effect OUT_READY_LATENCY cycles later
fill_level  output  ADDR_W+1  current FIFO occupancy, 0..FIFO_DEPTH

Behaviour:
- Interface: one clock, clk. Reset is reset_n, asynchronous, active-low. All registers clear on assertion; release is synchronous to clk.
- Reset values: in_ready=0 while reset_n=0, then 1 from the first cycle after release. out_valid=0, out_data=0, fill_level=0. Pointers=0. Ready delay line=all zeros.
- Ready delay line: shift register of OUT_READY_LATENCY bits loaded from out_ready each cycle.
  - grant = out_ready when OUT_READY_LATENCY=0; otherwise the oldest stage.
- Output: out_valid = grant && (fill_level!=0), combinational from registered state plus grant. out_data = FIFO head, shown as 0 when empty.
- Pop: occurs every cycle out_valid=1. There is no second handshake, because the sink is obliged to accept.
- Input: in_ready = (fill_level < FIFO_DEPTH), combinational from the registered count only. It does not depend on pop in the same cycle.
- Push: occurs when in_valid && in_ready. Data is written at the write pointer. It becomes visible at the head no earlier than the next cycle, so minimum latency in->out is 1 cycle when grant=1.
- Simultaneous push and pop: fill_level unchanged and both pointers advance. Legal at any level below full.
- Full: in_ready=0 and in_valid is ignored. A pop while full frees a slot for the following cycle, not the current one.
- Empty: out_valid=0 regardless of grant. A grant slot with no data is simply lost; there is no catch-up.
- Wrap-around: pointers are ADDR_W bits and wrap modulo FIFO_DEPTH. Ordering is strictly FIFO.
- Backpressure: sink drops out_ready at cycle t. Up to OUT_READY_LATENCY further beats may still be emitted (t..t+L-1), and none after that.
- Reset mid-operation: FIFO contents are discarded and the delay line is cleared. After release, out_valid stays 0 for at least OUT_READY_LATENCY cycles even if out_ready=1.
- Throughput: 1 beat/cycle sustained when out_ready is held high and in_valid is continuous.

Test Plan:
- Reset release, out_ready=1, L=1 -> in_ready=1 first cycle after release; out_valid=0 on cycle 1 (delay line empty); fill_level=0.
- Continuous in 0x01..0x10, out_ready=1 from reset, L=1 -> out_data 0x01..0x10 in order, one per cycle; fill_level never exceeds 1 after first beat; in_ready stays 1.
- Stream 0x20..0x2F, drop out_ready for 6 cycles mid-stream, L=2 -> exactly 2 beats still emitted after the drop. FIFO fills to 4, then in_ready=0. No byte lost or duplicated, order preserved on resume.
- Fill to FIFO_DEPTH=4 with out_ready=0, then hold in_valid=1 and raise out_ready -> no push in the full cycle. First pop appears L cycles after out_ready rises, and in_ready returns to 1 the cycle after that pop.
- Push/pop same cycle at fill_level=2, 5 cycles -> fill_level stays 2; write and read pointers wrap past 3->0 with data intact (e.g. 0xA0..0xA6 read in order).
- Assert reset_n=0 with fill_level=3 mid-stream -> out_valid=0 and fill_level=0 immediately (asynchronous). Old bytes never appear after release, and the first output is the first byte pushed after release.
